dcache_ctrl: RTL and testbench

Data-side responder for the MEM stage's data-memory port: a direct-mapped, write-through, no-write-allocate data cache that answers the stage's read/write requests and drives `miss` to stall the pipeline. Read hits return data combinationally in the request cycle. Read misses fill a whole line from backing memory over a req/ack port. Every write goes through to backing memory and stalls until it is acknowledged.

---
 rtl/dcache_pkg.sv | 21 ++
 rtl/dcache_if.sv | 29 ++
 rtl/dcache_merge.sv | 23 ++
 rtl/dcache_ctrl.sv | 162 ++++++++++++++++
 tb/tb_dcache_ctrl.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared size codes, FSM states and address-split widths for dcache_ctrl
package dcache_pkg;
  localparam logic [1:0] SZ_WORD = 2'd0;
  localparam logic [1:0] SZ_BYTE = 2'd1;
  localparam logic [1:0] SZ_HALF = 2'd2;
  localparam logic [1:0] SZ_TRI  = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_WRITE, S_WDONE} state_e;

  function automatic int word_bits(input int line_words);
    return $clog2(line_words);
  endfunction

  function automatic int index_bits(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int tag_bits(input int lines, input int line_words);
    return 30 - $clog2(lines) - $clog2(line_words);
  endfunction
endpackage

// File: rtl/dcache_if.sv
// rtl/dcache_if.sv - MEM-stage request/response and backing-memory port bundle
interface dcache_if;
  logic [31:0] data_address_2DM;
  logic [31:0] data_write_2DM;
  logic [1:0]  data_write_size_2DM;
  logic        MemRead_2DM;
  logic        MemWrite_2DM;
  logic [31:0] data_read_fDM;
  logic        miss;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [1:0]  mem_wsize;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport slave (
    input  data_address_2DM, data_write_2DM, data_write_size_2DM, MemRead_2DM, MemWrite_2DM,
    input  mem_rdata, mem_ack,
    output data_read_fDM, miss, mem_req, mem_we, mem_addr, mem_wdata, mem_wsize
  );

  modport master (
    output data_address_2DM, data_write_2DM, data_write_size_2DM, MemRead_2DM, MemWrite_2DM,
    output mem_rdata, mem_ack,
    input  data_read_fDM, miss, mem_req, mem_we, mem_addr, mem_wdata, mem_wsize
  );
endinterface

// File: rtl/dcache_merge.sv
// rtl/dcache_merge.sv - big-endian byte merge of a sized, possibly unaligned store into a word
module dcache_merge
  import dcache_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  output logic [31:0] merged
);
  // Data byte k (MSB first) lands on byte lane offset+k; lanes past 3 fall off the word.
  always_comb begin
    merged = old_word;
    if (size == SZ_WORD) begin
      merged = wdata;
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (k < int'(size) && (int'(offset) + k) < 4)
          merged[8*(3 - (int'(offset) + k)) +: 8] = wdata[8*(int'(size) - 1 - k) +: 8];
      end
    end
  end
endmodule

// File: rtl/dcache_ctrl.sv
// rtl/dcache_ctrl.sv - direct-mapped write-through, no-write-allocate data cache with line fill
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int LINES      = 64,
  parameter int LINE_WORDS = 4
) (
  input  logic     CLK,
  input  logic     RESET,
  dcache_if.slave  bus
);
  localparam int WW = word_bits(LINE_WORDS);
  localparam int IW = index_bits(LINES);
  localparam int TW = tag_bits(LINES, LINE_WORDS);

  state_e        state_q, state_d;
  logic [WW-1:0] beat_q, beat_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic [1:0]    mem_wsize_q, mem_wsize_d;

  logic [LINES-1:0] valid_q;
  logic [TW-1:0]    tag_q  [LINES];
  logic [31:0]      data_q [LINES*LINE_WORDS];

  logic [IW-1:0] req_idx;
  logic [WW-1:0] req_word;
  logic [TW-1:0] req_tag;
  logic [31:0]   line_base, cur_word, merged;
  logic          hit, ack;
  logic          fill_start, fill_we, fill_last, write_we;
  logic          miss_c;
  logic [31:0]   rdata_c;

  assign req_idx   = bus.data_address_2DM[2+WW +: IW];
  assign req_word  = bus.data_address_2DM[2 +: WW];
  assign req_tag   = bus.data_address_2DM[31 -: TW];
  assign line_base = {bus.data_address_2DM[31:2+WW], {(WW+2){1'b0}}};
  assign hit       = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign cur_word  = data_q[{req_idx, req_word}];
  assign ack       = bus.mem_ack & mem_req_q;

  dcache_merge u_merge (
    .old_word (cur_word),
    .wdata    (bus.data_write_2DM),
    .size     (bus.data_write_size_2DM),
    .offset   (bus.data_address_2DM[1:0]),
    .merged   (merged)
  );

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wsize_d = mem_wsize_q;
    fill_start  = 1'b0;
    fill_we     = 1'b0;
    fill_last   = 1'b0;
    write_we    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.MemWrite_2DM) begin
          state_d     = S_WRITE;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = bus.data_address_2DM;
          mem_wdata_d = bus.data_write_2DM;
          mem_wsize_d = bus.data_write_size_2DM;
        end else if (bus.MemRead_2DM && !hit) begin
          state_d    = S_FILL;
          fill_start = 1'b1;
          beat_d     = '0;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = line_base;
        end
      end
      S_FILL: begin
        if (ack) begin
          fill_we = 1'b1;
          beat_d  = beat_q + WW'(1);
          if (beat_q == WW'(LINE_WORDS - 1)) begin
            fill_last = 1'b1;
            state_d   = S_IDLE;
            mem_req_d = 1'b0;
          end else begin
            mem_addr_d = line_base + {{(30-WW){1'b0}}, beat_d, 2'b00};
          end
        end
      end
      S_WRITE: begin
        if (ack) begin
          write_we  = hit;
          state_d   = S_WDONE;
          mem_req_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      beat_q      <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wsize_q <= '0;
      valid_q     <= '0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wsize_q <= mem_wsize_d;
      // The line stays invalid while it is being refilled, so an aborted fill never hits.
      if (fill_start) valid_q[req_idx] <= 1'b0;
      if (fill_last)  valid_q[req_idx] <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      if (fill_we)       data_q[{req_idx, beat_q}]   <= bus.mem_rdata;
      else if (write_we) data_q[{req_idx, req_word}] <= merged;
      if (fill_last)     tag_q[req_idx]              <= req_tag;
    end
  end

  always_comb begin
    miss_c  = 1'b0;
    rdata_c = '0;
    case (state_q)
      S_IDLE: begin
        if (bus.MemWrite_2DM)     miss_c = 1'b1;
        else if (bus.MemRead_2DM) begin
          if (hit) rdata_c = cur_word;
          else     miss_c  = 1'b1;
        end
      end
      S_FILL, S_WRITE: miss_c = 1'b1;
      default: ;
    endcase
  end

  assign bus.miss          = miss_c;
  assign bus.data_read_fDM = rdata_c;
  assign bus.mem_req       = mem_req_q;
  assign bus.mem_we        = mem_we_q;
  assign bus.mem_addr      = mem_addr_q;
  assign bus.mem_wdata     = mem_wdata_q;
  assign bus.mem_wsize     = mem_wsize_q;
endmodule

// File: tb/tb_dcache_ctrl.sv
// tb/tb_dcache_ctrl.sv - directed and randomized checks of dcache_ctrl against a byte-level memory model
module tb_dcache_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dcache_if bus ();

  dcache_ctrl #(.LINES(64), .LINE_WORDS(4)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Backing memory as bytes; untouched bytes read a fixed address-derived pattern.
  logic [7:0] mem_b [logic [31:0]];
  bit          valid_m [64];
  logic [21:0] tag_m   [64];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%08h expected=%08h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] init_byte(input logic [31:0] a);
    return a[7:0] ^ a[17:10] ^ 8'hA5;
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    logic [31:0] b;
    w = '0;
    for (int k = 0; k < 4; k++) begin
      b = {a[31:2], 2'b00} + 32'(k);
      w[31-8*k -: 8] = mem_b.exists(b) ? mem_b[b] : init_byte(b);
    end
    return w;
  endfunction

  task automatic set_word(input logic [31:0] a, input logic [31:0] w);
    for (int k = 0; k < 4; k++) mem_b[{a[31:2], 2'b00} + 32'(k)] = w[31-8*k -: 8];
  endtask

  task automatic mem_write(input logic [31:0] a, input logic [31:0] wd, input logic [1:0] sz);
    int n;
    int o;
    n = (sz == 2'd0) ? 4 : int'(sz);
    o = (sz == 2'd0) ? 0 : int'(a[1:0]);
    for (int k = 0; k < n; k++)
      if (o + k < 4) mem_b[{a[31:2], 2'b00} + 32'(o + k)] = wd[8*(n-1-k) +: 8];
  endtask

  // Issues one request, plays backing memory with `lat` wait cycles per beat, checks stall and data.
  task automatic run_req(input bit is_wr, input bit also_rd, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [1:0] sz, input int lat,
                         output logic [31:0] rd);
    int  stall;
    int  wait_c;
    int  beats;
    int  exp_stall;
    bit  done;
    bit  was_hit;
    logic [5:0] idx;
    idx     = addr[9:4];
    was_hit = valid_m[idx] && (tag_m[idx] == addr[31:10]);
    exp_stall = is_wr ? lat + 2 : (was_hit ? 0 : 1 + 4 * (lat + 1));
    bus.data_address_2DM    = addr;
    bus.data_write_2DM      = wd;
    bus.data_write_size_2DM = sz;
    bus.MemWrite_2DM        = is_wr;
    bus.MemRead_2DM         = !is_wr || also_rd;
    stall = 0; wait_c = 0; beats = 0; done = 0; rd = '0;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      @(negedge clk);
      if (!bus.miss) begin
        rd   = bus.data_read_fDM;
        done = 1;
      end else begin
        stall++;
        if (bus.mem_req) begin
          if (wait_c == lat) begin
            bus.mem_ack = 1'b1;
            check("mem_we", {31'd0, bus.mem_we}, {31'd0, is_wr});
            if (is_wr) begin
              check("wr_addr", bus.mem_addr, addr);
              check("wr_data", bus.mem_wdata, wd);
              check("wr_size", {30'd0, bus.mem_wsize}, {30'd0, sz});
              mem_write(addr, wd, sz);
            end else begin
              check("fill_addr", bus.mem_addr, {addr[31:4], 4'h0} + 32'(4 * beats));
              bus.mem_rdata = mem_word(bus.mem_addr);
            end
            wait_c = 0;
            beats++;
          end else begin
            wait_c++;
          end
        end
      end
      @(posedge clk);
      #1;
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = '0;
    end
    if (!done) check("timeout", 32'd0, 32'd1);
    check(is_wr ? "wr_stall" : "rd_stall", 32'(stall), 32'(exp_stall));
    check(is_wr ? "wr_beats" : "rd_beats", 32'(beats), is_wr ? 32'd1 : (was_hit ? 32'd0 : 32'd4));
    if (is_wr) begin
      check("wr_rdata_zero", rd, 32'd0);
    end else begin
      check("rd_data", rd, mem_word(addr));
      valid_m[idx] = 1'b1;
      tag_m[idx]   = addr[31:10];
    end
    bus.MemRead_2DM  = 1'b0;
    bus.MemWrite_2DM = 1'b0;
  endtask

  logic [31:0] rd;
  int          beats_r;

  initial begin
    bus.data_address_2DM    = '0;
    bus.data_write_2DM      = '0;
    bus.data_write_size_2DM = '0;
    bus.MemRead_2DM         = 1'b0;
    bus.MemWrite_2DM        = 1'b0;
    bus.mem_rdata           = '0;
    bus.mem_ack             = 1'b0;
    for (int i = 0; i < 64; i++) begin valid_m[i] = 1'b0; tag_m[i] = '0; end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_miss", {31'd0, bus.miss}, 32'd0);
    check("rst_rdata", bus.data_read_fDM, 32'd0);
    check("rst_req", {31'd0, bus.mem_req}, 32'd0);
    check("rst_we", {31'd0, bus.mem_we}, 32'd0);
    check("rst_addr", bus.mem_addr, 32'd0);
    check("rst_wdata", bus.mem_wdata, 32'd0);
    check("rst_wsize", {30'd0, bus.mem_wsize}, 32'd0);
    @(posedge clk); #1;

    set_word(32'h100, 32'h11111111);
    set_word(32'h104, 32'h22222222);
    set_word(32'h108, 32'h33333333);
    set_word(32'h10C, 32'h44444444);
    run_req(0, 0, 32'h100, 0, 0, 1, rd);
    check("cold_0x100", rd, 32'h11111111);
    run_req(0, 0, 32'h108, 0, 0, 1, rd);
    check("hit_0x108", rd, 32'h33333333);
    run_req(1, 0, 32'h101, 32'h000000AB, 2'd1, 1, rd);
    run_req(0, 0, 32'h100, 0, 0, 1, rd);
    check("sb_merge", rd, 32'h11AB1111);
    run_req(1, 1, 32'h105, 32'h00CCDDEE, 2'd3, 0, rd);
    run_req(0, 0, 32'h104, 0, 0, 0, rd);
    check("tri_merge", rd, 32'h22CCDDEE);
    run_req(1, 0, 32'h2000, 32'hDEADBEEF, 2'd0, 2, rd);
    run_req(0, 0, 32'h2000, 0, 0, 0, rd);
    check("sw_nowa", rd, 32'hDEADBEEF);

    // Abort a fill with reset after its second beat.
    bus.data_address_2DM = 32'h4100;
    bus.MemRead_2DM      = 1'b1;
    beats_r = 0;
    for (int cyc = 0; cyc < 50 && beats_r < 2; cyc++) begin
      @(negedge clk);
      if (bus.mem_req) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = mem_word(bus.mem_addr);
        beats_r++;
      end
      @(posedge clk); #1;
      bus.mem_ack = 1'b0;
    end
    check("abort_beats", 32'(beats_r), 32'd2);
    @(negedge clk);
    check("pre_rst_req", {31'd0, bus.mem_req}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.MemRead_2DM = 1'b0;
    @(negedge clk);
    check("abort_req", {31'd0, bus.mem_req}, 32'd0);
    check("abort_miss", {31'd0, bus.miss}, 32'd0);
    for (int i = 0; i < 64; i++) valid_m[i] = 1'b0;
    @(posedge clk); #1;
    run_req(0, 0, 32'h100, 0, 0, 1, rd);
    check("refill_0x100", rd, 32'h11AB1111);
    run_req(0, 0, 32'h4100, 0, 0, 0, rd);

    for (int t = 0; t < 200; t++) begin
      logic [31:0] a;
      logic [31:0] wd;
      bit          wr;
      a  = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 7) << 4) | ($urandom_range(0, 3) << 2);
      wr = ($urandom_range(0, 1) == 1);
      wd = $urandom;
      if (wr) run_req(1, $urandom_range(0, 1) == 1, a | 32'($urandom_range(0, 3)), wd,
                      2'($urandom_range(0, 3)), $urandom_range(0, 2), rd);
      else    run_req(0, 0, a, 0, 0, $urandom_range(0, 2), rd);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
